// File: rtl/atomic_counter_read_arbiter_if.sv
// atomic_counter_read_arbiter_if: requester-side and counter-side signals of the read arbiter.
interface atomic_counter_read_arbiter_if #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0] rd_req_i;
  logic [NUM_REQ-1:0] rd_gnt_o;
  logic [NUM_REQ-1:0] rd_valid_o;
  logic [63:0]        rd_data_o;
  logic               busy_o;
  logic               ctr_req_o;
  logic               ctr_atomic_o;
  logic               ctr_ack_i;
  logic [31:0]        ctr_count_i;
  logic               proto_err_o;
  modport slave (
    input  rd_req_i, ctr_ack_i, ctr_count_i,
    output rd_gnt_o, rd_valid_o, rd_data_o, busy_o, ctr_req_o, ctr_atomic_o, proto_err_o
  );
  modport master (
    output rd_req_i, ctr_ack_i, ctr_count_i,
    input  rd_gnt_o, rd_valid_o, rd_data_o, busy_o, ctr_req_o, ctr_atomic_o, proto_err_o
  );
endinterface

// File: rtl/atomic_counter_read_arbiter.sv
// atomic_counter_read_arbiter: shares one atomic counter read port, returning coherent 64-bit counts.
// Define ACR_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module atomic_counter_read_arbiter #(
  parameter int NUM_REQ = 4
) (
  input logic clk,
  input logic reset,
  atomic_counter_read_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ISSUE_LO = 3'd1;
  localparam logic [2:0] ISSUE_HI = 3'd2;
  localparam logic [2:0] WAIT_HI  = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;
  logic [2:0]         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, win_idx;
  logic               win_found;
  logic [31:0]        lo_q;
  logic [63:0]        data_q;
  logic [NUM_REQ-1:0] gnt_q, valid_q;
  logic               err_q;
`ifndef ACR_FIXED_PRIO_EN
  logic [IDX_W-1:0]   ptr_q;
`endif
  // Last assignment wins, so iterate from lowest to highest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
`ifdef ACR_FIXED_PRIO_EN
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (bus.rd_req_i[k]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(k);
      end
`else
    for (int k = NUM_REQ; k >= 1; k--) begin
      int j;
      j = (int'(ptr_q) + k) % NUM_REQ;
      if (bus.rd_req_i[j]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(j);
      end
    end
`endif
  end
  always_comb begin
    state_d = (state_q == IDLE)     ? (win_found ? ISSUE_LO : IDLE) :
              (state_q == ISSUE_LO) ? ISSUE_HI :
              (state_q == ISSUE_HI) ? WAIT_HI :
              (state_q == WAIT_HI)  ? DONE : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      lo_q    <= '0;
      data_q  <= '0;
      gnt_q   <= '0;
      valid_q <= '0;
      err_q   <= 1'b0;
`ifndef ACR_FIXED_PRIO_EN
      ptr_q   <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= '0;
      valid_q <= '0;
      if (state_q == IDLE && win_found) begin
        owner_q <= win_idx;
        gnt_q   <= NUM_REQ'(1) << win_idx;
      end
      if (state_q == ISSUE_HI) lo_q <= bus.ctr_count_i;
      // Response is registered here so rd_valid_o/rd_data_o appear during DONE.
      if (state_q == WAIT_HI) begin
        data_q  <= {bus.ctr_count_i, lo_q};
        valid_q <= NUM_REQ'(1) << owner_q;
      end
      if ((state_q == ISSUE_HI || state_q == WAIT_HI) && !bus.ctr_ack_i) err_q <= 1'b1;
`ifndef ACR_FIXED_PRIO_EN
      if (state_q == DONE) ptr_q <= owner_q;
`endif
    end
  end
  assign bus.rd_gnt_o     = gnt_q;
  assign bus.rd_valid_o   = valid_q;
  assign bus.rd_data_o    = data_q;
  assign bus.busy_o       = state_q != IDLE;
  assign bus.ctr_req_o    = state_q == ISSUE_LO || state_q == ISSUE_HI;
  assign bus.ctr_atomic_o = state_q == ISSUE_LO;
  assign bus.proto_err_o  = err_q;
endmodule

// File: tb/tb_atomic_counter_read_arbiter.sv
// tb_atomic_counter_read_arbiter: directed checks of the arbiter against a preloadable counter stub.
module tb_atomic_counter_read_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int failed = 0;
  logic        load = 1'b0;
  logic [63:0] load_val = '0;
  logic        trig = 1'b0;
  logic        sup_hi = 1'b0;
  logic [63:0] cnt = '0;
  logic [31:0] shadow = '0;
  logic [31:0] count_q = '0;
  logic        ack_q = 1'b0;
  logic [3:0]  valid_seen;
  logic [3:0]  exp_g;

  atomic_counter_read_arbiter_if #(.NUM_REQ(4)) bus ();
  atomic_counter_read_arbiter #(.NUM_REQ(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Counter stub: atomic read returns lo and latches hi into the shadow; plain read returns the shadow.
  always_ff @(posedge clk) begin
    if (load) cnt <= load_val;
    else if (trig) cnt <= cnt + 64'd1;
    ack_q <= bus.ctr_req_o & ~(sup_hi & ~bus.ctr_atomic_o);
    if (bus.ctr_req_o) count_q <= bus.ctr_atomic_o ? cnt[31:0] : shadow;
    if (bus.ctr_req_o && bus.ctr_atomic_o) shadow <= cnt[63:32];
  end
  assign bus.ctr_ack_i   = ack_q;
  assign bus.ctr_count_i = count_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic read(input string tag, input logic [3:0] req, input logic [63:0] val,
                      input logic [3:0] exp_own, input logic [63:0] exp_data);
    bus.rd_req_i = req;
    load = 1'b1;
    load_val = val;
    tick();
    load = 1'b0;
    chk({tag, " gnt"}, 64'(bus.rd_gnt_o), 64'(exp_own));
    chk({tag, " req1"}, 64'({bus.ctr_req_o, bus.ctr_atomic_o}), 64'd3);
    tick();
    chk({tag, " req2"}, 64'({bus.ctr_req_o, bus.ctr_atomic_o, bus.rd_gnt_o}), 64'h20);
    tick();
    chk({tag, " wait"}, 64'({bus.ctr_req_o, bus.busy_o, bus.rd_valid_o}), 64'h10);
    tick();
    chk({tag, " valid"}, 64'(bus.rd_valid_o), 64'(exp_own));
    chk({tag, " data"}, bus.rd_data_o, exp_data);
    bus.rd_req_i = '0;
    tick();
    chk({tag, " idle"}, 64'({bus.busy_o, bus.rd_valid_o}), 64'd0);
    chk({tag, " hold"}, bus.rd_data_o, exp_data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rd_req_i = '0;
    tick();
    tick();
    chk("reset outs", 64'({bus.busy_o, bus.ctr_req_o, bus.ctr_atomic_o, bus.proto_err_o,
                          bus.rd_gnt_o, bus.rd_valid_o}), 64'd0);
    chk("reset data", bus.rd_data_o, 64'd0);
    reset = 1'b0;
    tick();
    read("single", 4'b0001, 64'h0000_0005_FFFF_FFFE, 4'b0001, 64'h0000_0005_FFFF_FFFE);
    trig = 1'b1;
    read("wrap", 4'b0100, 64'h0000_0001_FFFF_FFFF, 4'b0100, 64'h0000_0001_FFFF_FFFF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.rd_req_i = 4'b1111;
    for (int g = 0; g < 5; g++) begin
`ifdef ACR_FIXED_PRIO_EN
      exp_g = 4'b0001;
`else
      exp_g = 4'b0001 << (g % 4);
`endif
      tick();
      chk("rr gnt", 64'(bus.rd_gnt_o), 64'(exp_g));
      tick();
      tick();
      tick();
      chk("rr valid", 64'(bus.rd_valid_o), 64'(exp_g));
      if (g == 4) bus.rd_req_i = '0;
      tick();
      chk("rr idle", 64'({bus.busy_o, bus.rd_gnt_o}), 64'd0);
    end
    trig = 1'b0;
    chk("err clear", 64'(bus.proto_err_o), 64'd0);
    sup_hi = 1'b1;
    read("ackfault", 4'b0010, 64'h0000_0007_0000_0003, 4'b0010, 64'h0000_0007_0000_0003);
    sup_hi = 1'b0;
    chk("err set", 64'(bus.proto_err_o), 64'd1);
    read("after err", 4'b1000, 64'h0000_0009_0000_0001, 4'b1000, 64'h0000_0009_0000_0001);
    chk("err sticky", 64'(bus.proto_err_o), 64'd1);
    bus.rd_req_i = 4'b0001;
    tick();
    tick();
    chk("midop state", 64'({bus.ctr_req_o, bus.ctr_atomic_o}), 64'd2);
    reset = 1'b1;
    bus.rd_req_i = '0;
    #1;
    chk("midop outs", 64'({bus.busy_o, bus.ctr_req_o, bus.ctr_atomic_o, bus.proto_err_o,
                          bus.rd_gnt_o, bus.rd_valid_o}), 64'd0);
    chk("midop data", bus.rd_data_o, 64'd0);
    valid_seen = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      valid_seen = valid_seen | bus.rd_valid_o;
    end
    chk("midop novalid", 64'(valid_seen), 64'd0);
    reset = 1'b0;
    tick();
    read("post reset", 4'b0010, 64'h0000_0003_0000_0004, 4'b0010, 64'h0000_0003_0000_0004);
    bus.rd_req_i = 4'b0010;
    tick();
    chk("drop gnt", 64'(bus.rd_gnt_o), 64'b0010);
    bus.rd_req_i = '0;
    tick();
    tick();
    tick();
    chk("drop valid", 64'(bus.rd_valid_o), 64'b0010);
    tick();
    chk("drop idle", 64'({bus.busy_o, bus.rd_valid_o}), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
